// File: rtl/simt_scheduler.sv
// Per-core SIMT control FSM: sequences FETCH..UPDATE for one block, keeps a PC per
// thread and reconverges diverged threads by issuing to the minimum live PC.
module simt_scheduler #(
   parameter int THREADS = 4,
   parameter int PC_BITS = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [$clog2(THREADS):0]     thread_count,
   input  logic                         decoded_mem_read_enable,
   input  logic                         decoded_mem_write_enable,
   input  logic                         decoded_ret,
   input  logic [2:0]                   fetcher_state,
   input  logic [2*THREADS-1:0]         lsu_state,
   input  logic [PC_BITS*THREADS-1:0]   next_pc,
   output logic [PC_BITS-1:0]           current_pc,
   output logic [THREADS-1:0]           active_mask,
   output logic [2:0]                   core_state,
   output logic                         done
);

   localparam int TW = $clog2(THREADS) + 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      DECODE  = 3'd2,
      REQUEST = 3'd3,
      WAIT    = 3'd4,
      EXECUTE = 3'd5,
      UPDATE  = 3'd6,
      DONE    = 3'd7
   } state_t;

   state_t               state_q;
   logic [PC_BITS-1:0]   pc_q [THREADS];
   logic [THREADS-1:0]   enabled_q;
   logic [THREADS-1:0]   retired_q;
   logic [PC_BITS-1:0]   current_pc_q;
   logic [THREADS-1:0]   active_mask_q;
   logic                 done_q;

   logic [PC_BITS-1:0]   pc_upd_s [THREADS];
   logic [THREADS-1:0]   retired_upd_s;
   logic [THREADS-1:0]   live_s;
   logic [THREADS-1:0]   sel_mask_s;
   logic [THREADS-1:0]   en_s;
   logic [PC_BITS-1:0]   min_pc_s;
   logic                 any_live_s;
   logic                 wait_busy_s;
   logic                 mem_hint_unused_s;

   // The memory-enable hints are carried for future stall prediction only.
   assign mem_hint_unused_s = decoded_mem_read_enable ^ decoded_mem_write_enable;

   // Post-update PCs, live mask, min-PC reconvergence selection and LSU busy detect.
   always_comb begin
      retired_upd_s = retired_q | (decoded_ret ? active_mask_q : {THREADS{1'b0}});
      live_s        = enabled_q & ~retired_upd_s;
      min_pc_s      = {PC_BITS{1'b1}};
      any_live_s    = 1'b0;
      sel_mask_s    = {THREADS{1'b0}};
      wait_busy_s   = 1'b0;
      en_s          = {THREADS{1'b0}};
      for (int i = 0; i < THREADS; i++) begin
         pc_upd_s[i] = (active_mask_q[i] && !decoded_ret) ? next_pc[PC_BITS*i +: PC_BITS] : pc_q[i];
         en_s[i]     = (thread_count > TW'(i));
      end
      for (int i = 0; i < THREADS; i++) begin
         min_pc_s   = (live_s[i] && (!any_live_s || pc_upd_s[i] < min_pc_s)) ? pc_upd_s[i] : min_pc_s;
         any_live_s = any_live_s | live_s[i];
      end
      for (int i = 0; i < THREADS; i++) begin
         sel_mask_s[i] = live_s[i] && (pc_upd_s[i] == min_pc_s);
         // Only threads issued this instruction can hold the core in WAIT.
         wait_busy_s   = wait_busy_s | (active_mask_q[i] &&
                         ((lsu_state[2*i +: 2] == 2'b01) || (lsu_state[2*i +: 2] == 2'b10)));
      end
   end

   // Control FSM with registered outputs and per-thread state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         current_pc_q  <= {PC_BITS{1'b0}};
         active_mask_q <= {THREADS{1'b0}};
         done_q        <= 1'b0;
         enabled_q     <= {THREADS{1'b0}};
         retired_q     <= {THREADS{1'b0}};
         for (int i = 0; i < THREADS; i++) pc_q[i] <= {PC_BITS{1'b0}};
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  enabled_q <= en_s;
                  retired_q <= {THREADS{1'b0}};
                  if (thread_count == {TW{1'b0}}) begin
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     for (int i = 0; i < THREADS; i++) pc_q[i] <= {PC_BITS{1'b0}};
                     current_pc_q  <= {PC_BITS{1'b0}};
                     active_mask_q <= en_s;
                     state_q       <= FETCH;
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
            FETCH: begin
               if (fetcher_state == 3'b010) state_q <= DECODE;
               else                         state_q <= FETCH;
            end
            DECODE:  state_q <= REQUEST;
            REQUEST: state_q <= WAIT;
            WAIT: begin
               if (wait_busy_s) state_q <= WAIT;
               else             state_q <= EXECUTE;
            end
            EXECUTE: state_q <= UPDATE;
            UPDATE: begin
               for (int i = 0; i < THREADS; i++) pc_q[i] <= pc_upd_s[i];
               retired_q <= retired_upd_s;
               if (any_live_s) begin
                  current_pc_q  <= min_pc_s;
                  active_mask_q <= sel_mask_s;
                  state_q       <= FETCH;
               end else begin
                  done_q        <= 1'b1;
                  active_mask_q <= {THREADS{1'b0}};
                  state_q       <= DONE;
               end
            end
            DONE:    state_q <= DONE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign current_pc  = current_pc_q;
   assign active_mask = active_mask_q;
   assign core_state  = state_q;
   assign done        = done_q;

endmodule

// File: tb/tb_simt_scheduler.sv
// Directed self-checking bench for simt_scheduler (THREADS=4, PC_BITS=8).
module tb_simt_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  thread_count;
   logic        mem_rd, mem_wr, ret;
   logic [2:0]  fetcher_state;
   logic [7:0]  lsu_state;
   logic [31:0] next_pc;
   logic [7:0]  current_pc;
   logic [3:0]  active_mask;
   logic [2:0]  core_state;
   logic        done;

   int total = 0;
   int bad   = 0;

   simt_scheduler #(.THREADS(4), .PC_BITS(8)) dut (
      .clk                      (clk),
      .reset                    (reset),
      .start                    (start),
      .thread_count             (thread_count),
      .decoded_mem_read_enable  (mem_rd),
      .decoded_mem_write_enable (mem_wr),
      .decoded_ret              (ret),
      .fetcher_state            (fetcher_state),
      .lsu_state                (lsu_state),
      .next_pc                  (next_pc),
      .current_pc               (current_pc),
      .active_mask              (active_mask),
      .core_state               (core_state),
      .done                     (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      ret   = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   // From FETCH (fetcher ready): runs one instruction through UPDATE.
   task automatic run_instr(input string tag, input logic [7:0] n3, input logic [7:0] n2,
                            input logic [7:0] n1, input logic [7:0] n0, input logic r);
      next_pc = {n3, n2, n1, n0};
      ret     = r;
      repeat (5) tick();
      chk({tag, "_update"}, 32'(core_state), 32'd6);
      tick();
      ret = 1'b0;
   endtask

   task automatic chk_issue(input string tag, input logic [7:0] pc, input logic [3:0] m);
      chk({tag, "_state"}, 32'(core_state), 32'd1);
      chk({tag, "_pc"}, 32'(current_pc), 32'(pc));
      chk({tag, "_mask"}, 32'(active_mask), 32'(m));
   endtask

   initial begin
      start = 1'b0; thread_count = 3'd0; mem_rd = 1'b0; mem_wr = 1'b0; ret = 1'b0;
      fetcher_state = 3'b010; lsu_state = 8'h00; next_pc = 32'h0; reset = 1'b0;

      // Reset state
      do_reset();
      chk("rst_state", 32'(core_state), 32'd0);
      chk("rst_pc", 32'(current_pc), 32'd0);
      chk("rst_mask", 32'(active_mask), 32'd0);
      chk("rst_done", 32'(done), 32'd0);

      // Test 1: linear program, RET at pc 3, first fetch takes 3 cycles
      thread_count = 3'd4; start = 1'b1; fetcher_state = 3'b000;
      tick();
      start = 1'b0;
      chk_issue("t1_launch", 8'd0, 4'hF);
      tick();
      chk("t1_fetch_hold1", 32'(core_state), 32'd1);
      tick();
      chk("t1_fetch_hold2", 32'(core_state), 32'd1);
      fetcher_state = 3'b010;
      run_instr("t1_i0", 8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
      chk_issue("t1_pc1", 8'd1, 4'hF);
      run_instr("t1_i1", 8'd2, 8'd2, 8'd2, 8'd2, 1'b0);
      chk_issue("t1_pc2", 8'd2, 4'hF);
      run_instr("t1_i2", 8'd3, 8'd3, 8'd3, 8'd3, 1'b0);
      chk_issue("t1_pc3", 8'd3, 4'hF);
      run_instr("t1_i3", 8'd4, 8'd4, 8'd4, 8'd4, 1'b1);
      chk("t1_done", 32'(done), 32'd1);
      chk("t1_state", 32'(core_state), 32'd7);
      chk("t1_mask", 32'(active_mask), 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t1_done_hold", 32'(core_state), 32'd7);
      chk("t1_pc_hold", 32'(current_pc), 32'd3);

      // Test 2: divergence at pc 2, reconvergence at pc 5; count 7 clamps to 4
      do_reset();
      thread_count = 3'd7; start = 1'b1;
      tick();
      start = 1'b0;
      chk_issue("t2_launch", 8'd0, 4'hF);
      run_instr("t2_i0", 8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
      run_instr("t2_i1", 8'd2, 8'd2, 8'd2, 8'd2, 1'b0);
      chk_issue("t2_pc2", 8'd2, 4'hF);
      run_instr("t2_i2", 8'd3, 8'd3, 8'd5, 8'd5, 1'b0);
      chk_issue("t2_pc3", 8'd3, 4'b1100);
      run_instr("t2_i3", 8'd4, 8'd4, 8'hEE, 8'hEE, 1'b0);
      chk_issue("t2_pc4", 8'd4, 4'b1100);
      run_instr("t2_i4", 8'd5, 8'd5, 8'hEE, 8'hEE, 1'b0);
      chk_issue("t2_pc5", 8'd5, 4'hF);
      run_instr("t2_i5", 8'd6, 8'd6, 8'd6, 8'd6, 1'b1);
      chk("t2_done", 32'(done), 32'd1);

      // Test 3: count=2, inactive threads' LSUs busy must not stall WAIT
      do_reset();
      thread_count = 3'd2; lsu_state = 8'hA0; mem_rd = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      chk_issue("t3_launch", 8'd0, 4'b0011);
      repeat (3) tick();
      chk("t3_wait", 32'(core_state), 32'd4);
      tick();
      chk("t3_exec", 32'(core_state), 32'd5);
      ret = 1'b1;
      repeat (2) tick();
      ret = 1'b0;
      chk("t3_done", 32'(core_state), 32'd7);
      lsu_state = 8'h00; mem_rd = 1'b0;

      // Test 4: active thread 1 WAITING for 5 cycles in WAIT
      do_reset();
      thread_count = 3'd4; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (2) tick();
      lsu_state = 8'h08;
      tick();
      chk("t4_wait_c1", 32'(core_state), 32'd4);
      for (int k = 2; k <= 5; k++) begin
         tick();
         chk($sformatf("t4_wait_c%0d", k), 32'(core_state), 32'd4);
      end
      lsu_state = 8'h00;
      tick();
      chk("t4_exec", 32'(core_state), 32'd5);
      next_pc = {8'd4, 8'd4, 8'd4, 8'd4};
      repeat (2) tick();
      chk_issue("t4_pc4", 8'd4, 4'hF);

      // Test 6: reset in WAIT with pc=4, then relaunch from pc 0
      repeat (3) tick();
      chk("t6_in_wait", 32'(core_state), 32'd4);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_state", 32'(core_state), 32'd0);
      chk("t6_pc", 32'(current_pc), 32'd0);
      chk("t6_mask", 32'(active_mask), 32'd0);
      chk("t6_done", 32'(done), 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk_issue("t6_relaunch", 8'd0, 4'hF);

      // Test 5: count=0 finishes immediately
      do_reset();
      thread_count = 3'd0; start = 1'b1;
      tick();
      chk("t5_done", 32'(done), 32'd1);
      chk("t5_state", 32'(core_state), 32'd7);
      chk("t5_mask", 32'(active_mask), 32'd0);
      tick();
      start = 1'b0;
      chk("t5_hold", 32'(core_state), 32'd7);

      // Wrap: single thread steps 0 -> 255 -> 0
      do_reset();
      thread_count = 3'd1; start = 1'b1;
      tick();
      start = 1'b0;
      chk_issue("tw_launch", 8'd0, 4'b0001);
      run_instr("tw_i0", 8'd9, 8'd9, 8'd9, 8'd255, 1'b0);
      chk_issue("tw_pc255", 8'd255, 4'b0001);
      run_instr("tw_i1", 8'd9, 8'd9, 8'd9, 8'd0, 1'b0);
      chk_issue("tw_pc0", 8'd0, 4'b0001);
      run_instr("tw_i2", 8'd9, 8'd9, 8'd9, 8'd1, 1'b1);
      chk("tw_done", 32'(done), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
